// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a hardware reset walker,
// a per-entry busy scoreboard and a dedicated PC port on the top entry.
// Optional macro REGFILE_SB_BYPASS_EN adds same-cycle write-to-read forwarding.

module regfile_sb #(
   parameter int DW  = 32,
   parameter int AW  = 4,
   parameter int NRD = 3
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic [NRD*AW-1:0] rA,
   output logic [NRD*DW-1:0] rD,
   output logic [NRD-1:0]    rBusy,
   input  logic              wEn1,
   input  logic [AW-1:0]     wA1,
   input  logic [DW-1:0]     wD1,
   input  logic              wEn15,
   input  logic [DW-1:0]     wDr15,
   output logic [DW-1:0]     rDr15,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_a
);

   localparam int            DEPTH  = 2 ** AW;
   localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   mem_q [DEPTH];
   logic [DW-1:0]   mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;

   // Walker sequencing: step through every entry once, then enter RUN; rst restarts the walk
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PC_IDX) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = INIT;
         end
      endcase
      if (rst) begin
         state_d = INIT;
         cnt_d   = '0;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Array and scoreboard next state: walker clears one entry per cycle, RUN applies writes and issue marks
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (!rst) begin
         if (state_q == INIT) begin
            mem_d[cnt_q]  = '0;
            busy_d[cnt_q] = 1'b0;
         end else begin
            if (wEn1) begin
               mem_d[wA1]  = wD1;
               busy_d[wA1] = 1'b0;
            end
            // PC write comes after the main write so it wins on a collision at the top entry
            if (wEn15) begin
               mem_d[PC_IDX] = wDr15;
            end
            // A new producer supersedes one retiring to the same entry in this cycle
            if (iss_en) begin
               busy_d[iss_a] = 1'b1;
            end
         end
      end
   end

   // Storage registers; cleared by the walker rather than by rst directly
   always_ff @(posedge clk) begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
   end

   assign ready = (state_q == RUN);

   // Combinational read ports; everything reads zero until the walk has finished
   always_comb begin
      rD    = '0;
      rBusy = '0;
      rDr15 = '0;
      if (state_q == RUN) begin
         rDr15 = mem_q[PC_IDX];
`ifdef REGFILE_SB_BYPASS_EN
         if (wEn15 && !rst) begin
            rDr15 = wDr15;
         end
`endif
         for (int i = 0; i < NRD; i++) begin
            rD[i*DW +: DW] = mem_q[rA[i*AW +: AW]];
            rBusy[i]       = busy_q[rA[i*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
            if (wEn15 && !rst && (rA[i*AW +: AW] == PC_IDX)) begin
               rD[i*DW +: DW] = wDr15;
            end else if (wEn1 && !rst && (rA[i*AW +: AW] == wA1)) begin
               rD[i*DW +: DW] = wD1;
            end
            if (wEn1 && !rst && (rA[i*AW +: AW] == wA1)) begin
               rBusy[i] = 1'b0;
            end
`endif
         end
      end
   end

endmodule
